// File: rtl/spi_master_shifter_if.sv
// Config, strobe and serial-pin bundle between the APB-side control and the SPI shifter.
// master = control/pin side driving configuration and miso; slave = the shift engine.
interface spi_master_shifter_if #(
  parameter int DATA_W = 8
);
  logic              mstr;
  logic              cpol;
  logic              cpha;
  logic              lsbfe;
  logic              spiswai;
  logic [1:0]        spi_mode;
  logic [2:0]        sppr;
  logic [2:0]        spr;
  logic              send_data;
  logic [DATA_W-1:0] data_mosi;
  logic              miso;
  logic              sclk;
  logic              mosi;
  logic              ss;
  logic              tip;
  logic              receive_data;
  logic [DATA_W-1:0] data_miso;

  modport master (
    output mstr, cpol, cpha, lsbfe, spiswai, spi_mode, sppr, spr,
           send_data, data_mosi, miso,
    input  sclk, mosi, ss, tip, receive_data, data_miso
  );

  modport slave (
    input  mstr, cpol, cpha, lsbfe, spiswai, spi_mode, sppr, spr,
           send_data, data_mosi, miso,
    output sclk, mosi, ss, tip, receive_data, data_miso
  );
endinterface

// File: rtl/spi_master_shifter.sv
// SPI master shift engine: one DATA_W-bit transfer per send_data, 2*DATA_W SCLK edges of H cycles.
// Transfer takes 16*H cycles after the start cycle; wait/stop modes freeze SCLK, mstr=0 aborts.
module spi_master_shifter #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 11
) (
  input logic              PCLK,
  input logic              Presetn,
  spi_master_shifter_if.slave bus
);

  localparam int EW = $clog2(2 * DATA_W) + 1;
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  half_q, cnt_q;
  logic [EW-1:0]     edge_q;
  logic              cpol_q, cpha_q, lsbfe_q;
  logic [DATA_W-1:0] tx_q, rx_q, data_miso_q;
  logic              sclk_q, mosi_q, ss_q, tip_q, rcv_q;

  logic              freeze_d, tick_d, shift_d, sample_d, first_bit_d, next_bit_d;
  logic [CNT_W-1:0]  pre_d, half_d;
  logic [EW-1:0]     edge_d;
  logic [DATA_W-1:0] tx_d, rx_d;

  always_comb begin
    freeze_d    = (bus.spi_mode == 2'b01 && bus.spiswai) || bus.spi_mode[1];
    pre_d       = CNT_W'(bus.sppr) + CNT_W'(1);
    half_d      = pre_d << bus.spr;
    tick_d      = (state_q == XFER) && !freeze_d && (cnt_q == half_q - CNT_W'(1));
    edge_d      = edge_q + EW'(1);
    // cpha=0 shifts on even edges short of the last; cpha=1 on odd edges after the first
    shift_d     = tick_d && (cpha_q ? (edge_d[0] && edge_d != EW'(1))
                                    : (!edge_d[0] && edge_d != LAST_EDGE));
    sample_d    = tick_d && (cpha_q ? !edge_d[0] : edge_d[0]);
    tx_d        = lsbfe_q ? (tx_q >> 1) : (tx_q << 1);
    rx_d        = lsbfe_q ? {bus.miso, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], bus.miso};
    first_bit_d = bus.lsbfe ? bus.data_mosi[0] : bus.data_mosi[DATA_W-1];
    next_bit_d  = lsbfe_q ? tx_q[1] : tx_q[DATA_W-2];
  end

  always_ff @(posedge PCLK) begin
    if (!Presetn) begin
      state_q     <= IDLE;
      half_q      <= '0;
      cnt_q       <= '0;
      edge_q      <= '0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      lsbfe_q     <= 1'b0;
      tx_q        <= '0;
      rx_q        <= '0;
      data_miso_q <= '0;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      ss_q        <= 1'b1;
      tip_q       <= 1'b0;
      rcv_q       <= 1'b0;
    end else begin
      rcv_q <= 1'b0;
      case (state_q)
        IDLE: begin
          sclk_q <= bus.cpol;
          ss_q   <= 1'b1;
          tip_q  <= 1'b0;
          cnt_q  <= '0;
          edge_q <= '0;
          if (bus.send_data && bus.mstr && bus.spi_mode != 2'b11) begin
            state_q <= XFER;
            ss_q    <= 1'b0;
            tip_q   <= 1'b1;
            cpol_q  <= bus.cpol;
            cpha_q  <= bus.cpha;
            lsbfe_q <= bus.lsbfe;
            half_q  <= half_d;
            tx_q    <= bus.data_mosi;
            rx_q    <= '0;
            mosi_q  <= first_bit_d;
          end
        end
        XFER: begin
          if (!bus.mstr) begin
            state_q <= IDLE;
            ss_q    <= 1'b1;
            tip_q   <= 1'b0;
            sclk_q  <= cpol_q;
          end else if (tick_d) begin
            cnt_q  <= '0;
            edge_q <= edge_d;
            sclk_q <= ~sclk_q;
            if (shift_d) begin
              tx_q   <= tx_d;
              mosi_q <= next_bit_d;
            end
            if (sample_d) rx_q <= rx_d;
            if (edge_d == LAST_EDGE) begin
              state_q     <= DONE;
              ss_q        <= 1'b1;
              tip_q       <= 1'b0;
              sclk_q      <= cpol_q;
              rcv_q       <= 1'b1;
              data_miso_q <= sample_d ? rx_d : rx_q;
            end
          end else if (!freeze_d) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.sclk         = sclk_q;
  assign bus.mosi         = mosi_q;
  assign bus.ss           = ss_q;
  assign bus.tip          = tip_q;
  assign bus.receive_data = rcv_q;
  assign bus.data_miso    = data_miso_q;

endmodule

// File: doc/spi_master_shifter.md
Name: spi_master_shifter

Overview:
SPI master transfer engine directly downstream of the APB slave interface. It consumes the configuration fields, the send_data strobe and the data_mosi byte, and generates SCLK, MOSI and SS. It shifts in MISO and returns the received byte on data_miso with a one-cycle receive_data strobe. It also drives tip, which the APB slave interface uses for SPIF/SPTEF and status.

Parameters:
DATA_W, 8, transfer width in bits; the sequence below is written for 8.
CNT_W, 11, baud counter width; holds a half-period of up to 1024 PCLK cycles.

Ports:
PCLK  in  1  system clock; all logic on rising edge
Presetn  in  1  reset, synchronous, active-low
mstr  in  1  master enable; 0 = block idle, SS held high
cpol  in  1  SCLK idle level
cpha  in  1  0 = sample on leading edge; 1 = sample on trailing edge
lsbfe  in  1  1 = LSB first; 0 = MSB first
spiswai  in  1  stop SCLK while in wait mode
spi_mode  in  2  00 run, 01 wait, 10/11 stop
sppr  in  3  baud pre-selector
spr  in  3  baud selector
send_data  in  1  one-cycle start strobe
data_mosi  in  8  byte to transmit; sampled with send_data
miso  in  1  serial input
sclk  out  1  SPI clock
mosi  out  1  serial output
ss  out  1  slave select, active-low
tip  out  1  transfer in progress
receive_data  out  1  one-cycle strobe; data_miso valid
data_miso  out  8  last received byte

Behaviour:
- Reset (Presetn=0 at a PCLK edge): sclk=0, mosi=0, ss=1, tip=0, receive_data=0, data_miso=0x00, state IDLE, counters=0. This also applies mid-transfer, with no receive_data strobe.
- Half-period H = (sppr+1) << spr PCLK cycles (range 1..1024). Configuration is sampled at the start of the transfer and held until it ends.
- States:
  - IDLE: sclk=cpol, ss=1, tip=0. IDLE -> XFER when send_data=1, mstr=1 and spi_mode!=11.
  - XFER: on the entry cycle T0, ss=0 and tip=1, and the shift register has been loaded from data_mosi. The baud counter counts 0..H-1; at wrap an SCLK edge fires and sclk toggles. After edge 16 the block goes to DONE.
  - DONE: lasts 1 cycle; sclk=cpol, ss=1, tip=0, receive_data=1, data_miso updated. DONE -> IDLE.
- Edge k is visible on sclk at T0+k*H, and DONE is at cycle T0+16*H.
- Bit order: mosi = lsbfe ? sreg[0] : sreg[7]; the shift direction matches.
- cpha=0: bit 0 is driven on mosi from T0. miso is sampled on odd edges (1,3,..,15). The next bit is shifted out on even edges 2..14.
- cpha=1: a bit is driven on odd edges. miso is sampled on even edges (2..16).
- Received bits assemble in the order given by lsbfe, so loopback (miso=mosi) returns the transmitted byte.
- Wait/stop:
  - spi_mode=01 with spiswai=1: the baud counter and sclk freeze while the condition holds; the transfer resumes on exit.
  - spi_mode=01 with spiswai=0: normal operation.
  - spi_mode=10/11: freeze, same as wait-with-spiswai.
- send_data while in XFER or DONE: ignored; the shift register is not reloaded.
- mstr falls during XFER: abort to IDLE next cycle. ss=1, tip=0, sclk=cpol; no receive_data strobe; data_miso unchanged.
- send_data and the DONE cycle coincide: ignored. A new transfer needs a send_data pulse while in IDLE.
- receive_data is exactly one cycle wide. data_miso holds its value until the next completed transfer.

Test Plan:
- sppr=0, spr=0, cpol=0, cpha=0, lsbfe=0, data_mosi=0xA5, miso looped to mosi, send_data pulse:
  - ss=0 and tip=1 for 16 cycles; 16 sclk toggles.
  - mosi sequence 1,0,1,0,0,1,0,1.
  - receive_data pulses once; data_miso=0xA5.
- sppr=1, spr=1 (H=4), cpol=1, cpha=1, miso tied 1:
  - sclk idles 1; first toggle at T0+4; tip high 64 cycles.
  - data_miso=0xFF.
- lsbfe=1, data_mosi=0x01, loopback: first mosi bit is 1; data_miso=0x01.
- Mid-transfer spi_mode=01 with spiswai=1 for 10 cycles: sclk holds its level and tip stays 1; completion is delayed exactly 10 cycles; data correct.
- mstr dropped after edge 5: next cycle ss=1, tip=0, sclk=cpol; no receive_data; data_miso keeps its previous value.
- Presetn=0 mid-transfer, then a second send_data during XFER: all outputs return to reset values; the second strobe during XFER is ignored.
